// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv_core flush control plane: word type, flush FSM
// states and the debug snapshot exported by the flush responder.
package hsv_core_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2,
    ACK      = 2'd3
  } flush_state_t;

  // Count is zero-extended to a fixed width so the struct does not depend
  // on the MaxOutstanding parameter of any particular instance.
  typedef struct packed {
    flush_state_t state;
    logic [7:0]   count;
    logic         full;
    logic         empty;
  } flush_dbg_t;

endpackage

// File: rtl/hsv_core_flush_inflight_counter.sv
// Saturating up/down counter of in-flight fetch memory requests.
// count_nxt_o is the fire-based next value, before any clear.
module hsv_core_flush_inflight_counter #(
  parameter int MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                inc_i,
  input  logic                                dec_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] count_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] count_nxt_o,
  output logic                                full_o,
  output logic                                empty_o
);

  localparam int CountW = $clog2(MaxOutstanding + 1);
  localparam logic [CountW-1:0] MaxCount = CountW'(MaxOutstanding);

  logic [CountW-1:0] count_q;
  logic [CountW-1:0] count_d;

  assign full_o  = (count_q == MaxCount);
  assign empty_o = (count_q == '0);

  // Simultaneous inc and dec cancel; each alone saturates at its bound.
  always_comb begin
    count_nxt_o = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_nxt_o = count_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      count_nxt_o = count_q - 1'b1;
    end
  end

  assign count_d = clear_i ? '0 : count_nxt_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hsv_core_flush_responder.sv
// Responder side of the core flush four-phase handshake: flush, drain, redirect, ack.
// Optional drain watchdog enabled by defining HSV_CORE_FLUSH_TIMEOUT_EN.
module hsv_core_flush_responder
  import hsv_core_pkg::*;
#(
  parameter int NumStages      = 4,
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 1024
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  input  logic                 flush_req,
  input  word                  flush_target,
  output logic                 flush_ack,
  output logic                 stage_flush,
  input  logic [NumStages-1:0] stage_idle,
  input  logic                 fetch_req_fire,
  input  logic                 fetch_rsp_fire,
  output logic                 fetch_halt,
  output logic                 redirect_valid,
  output word                  redirect_pc,
  input  logic                 redirect_ready,
  output logic                 drain_timeout,
  output flush_dbg_t           dbg_o
);

  localparam int CountW = $clog2(MaxOutstanding + 1);

  flush_state_t      state_q, state_d;
  word               redirect_pc_q, redirect_pc_d;
  logic [CountW-1:0] cnt_q, cnt_nxt;
  logic              cnt_full, cnt_empty, cnt_clear;
  logic              drain_done, timer_expired;

  hsv_core_flush_inflight_counter #(
    .MaxOutstanding(MaxOutstanding)
  ) u_inflight (
    .clk_i      (clk_core),
    .rst_i      (rst_core),
    .clear_i    (cnt_clear),
    .inc_i      (fetch_req_fire),
    .dec_i      (fetch_rsp_fire),
    .count_o    (cnt_q),
    .count_nxt_o(cnt_nxt),
    .full_o     (cnt_full),
    .empty_o    (cnt_empty)
  );

  // Exit decision looks at the count after this cycle's fires.
  assign drain_done = (&stage_idle) && (cnt_nxt == '0);
  assign cnt_clear  = timer_expired;

`ifdef HSV_CORE_FLUSH_TIMEOUT_EN
  localparam int TimerW = $clog2(TimeoutCycles + 1);

  logic [TimerW-1:0] timer_q;
  logic              timeout_q;
  logic              timeout_set;

  assign timer_expired = (state_q == DRAIN) && (timer_q == TimerW'(TimeoutCycles - 1));
  assign timeout_set   = timer_expired && !drain_done;

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q <= (state_q == DRAIN) ? timer_q + 1'b1 : '0;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign drain_timeout = timeout_q;
`else
  assign timer_expired = 1'b0;
  assign drain_timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          redirect_pc_d = flush_target;
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done || timer_expired) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = ACK;
        end
      end
      ACK: begin
        // A new request needs the low phase first, so a held req stays here.
        if (!flush_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign stage_flush    = (state_q == DRAIN) || (state_q == REDIRECT);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush_ack      = (state_q == ACK);
  assign fetch_halt     = stage_flush || cnt_full;
  assign redirect_pc    = redirect_pc_q;

  assign dbg_o.state = state_q;
  assign dbg_o.count = 8'(cnt_q);
  assign dbg_o.full  = cnt_full;
  assign dbg_o.empty = cnt_empty;

endmodule

// File: tb/tb_hsv_core_flush_responder.sv
// Directed bench for hsv_core_flush_responder; the watchdog case runs only
// when HSV_CORE_FLUSH_TIMEOUT_EN is defined.
module tb_hsv_core_flush_responder;
  import hsv_core_pkg::*;

  localparam int TO = 16;

  logic       clk_core = 1'b0;
  logic       rst_core;
  logic       flush_req;
  word        flush_target;
  logic       flush_ack;
  logic       stage_flush;
  logic [3:0] stage_idle;
  logic       fetch_req_fire;
  logic       fetch_rsp_fire;
  logic       fetch_halt;
  logic       redirect_valid;
  word        redirect_pc;
  logic       redirect_ready;
  logic       drain_timeout;
  flush_dbg_t dbg;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_core = ~clk_core;

  hsv_core_flush_responder #(
    .NumStages     (4),
    .MaxOutstanding(4),
    .TimeoutCycles (TO)
  ) dut (
    .clk_core      (clk_core),
    .rst_core      (rst_core),
    .flush_req     (flush_req),
    .flush_target  (flush_target),
    .flush_ack     (flush_ack),
    .stage_flush   (stage_flush),
    .stage_idle    (stage_idle),
    .fetch_req_fire(fetch_req_fire),
    .fetch_rsp_fire(fetch_rsp_fire),
    .fetch_halt    (fetch_halt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .redirect_ready(redirect_ready),
    .drain_timeout (drain_timeout),
    .dbg_o         (dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  // ack, stage_flush, fetch_halt, redirect_valid
  task automatic check_outs(input string tag, input logic ack, input logic sf,
                            input logic halt, input logic rv);
    check({tag, ".ack"},   32'(flush_ack),      32'(ack));
    check({tag, ".sf"},    32'(stage_flush),    32'(sf));
    check({tag, ".halt"},  32'(fetch_halt),     32'(halt));
    check({tag, ".rv"},    32'(redirect_valid), 32'(rv));
  endtask

  task automatic check_state(input string tag, input flush_state_t st, input int cnt);
    check({tag, ".state"}, 32'(dbg.state), 32'(st));
    check({tag, ".count"}, 32'(dbg.count), 32'(cnt));
  endtask

  initial begin
    rst_core       = 1'b1;
    flush_req      = 1'b0;
    flush_target   = '0;
    stage_idle     = 4'b1111;
    fetch_req_fire = 1'b0;
    fetch_rsp_fire = 1'b0;
    redirect_ready = 1'b1;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.pc", redirect_pc, 32'h0);
    check("reset.to", 32'(drain_timeout), 32'h0);
    check_state("reset", IDLE, 0);
    rst_core = 1'b0;
    tick();

    // Counter bounds while idle.
    fetch_rsp_fire = 1'b1;
    tick();
    check_state("sat_zero", IDLE, 0);
    fetch_rsp_fire = 1'b0;
    fetch_req_fire = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_state("fill4", IDLE, 4);
    check("fill4.halt", 32'(fetch_halt), 32'h1);
    tick();
    check_state("sat_max", IDLE, 4);
    fetch_req_fire = 1'b0;
    fetch_rsp_fire = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    fetch_rsp_fire = 1'b0;
    check_state("empty", IDLE, 0);
    check("empty.halt", 32'(fetch_halt), 32'h0);

    // Best-case latency, request in cycle N.
    flush_req    = 1'b1;
    flush_target = 32'h0000_1000;
    tick();
    check_outs("lat_n1", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("lat_n2", 1'b0, 1'b1, 1'b1, 1'b1);
    check("lat_n2.pc", redirect_pc, 32'h0000_1000);
    tick();
    check_outs("lat_n3", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("lat_n4.ack", 32'(flush_ack), 32'h1);
    tick();
    check("lat_n5.ack", 32'(flush_ack), 32'h1);
    flush_req = 1'b0;
    tick();
    check("lat_n6.ack", 32'(flush_ack), 32'h0);
    check_state("lat_n6", IDLE, 0);

    // Drain with three outstanding fetches returning at +2, +5, +9.
    fetch_req_fire = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    fetch_req_fire = 1'b0;
    check_state("pre_drain", IDLE, 3);
    flush_req    = 1'b1;
    flush_target = 32'h0000_2000;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("drain_c%0d.rv", i), 32'(redirect_valid), 32'(i == 10));
      fetch_rsp_fire = (i == 2) || (i == 5) || (i == 9);
    end
    check("drain.pc", redirect_pc, 32'h0000_2000);
    tick();
    check("drain.ack", 32'(flush_ack), 32'h1);
    flush_req = 1'b0;
    tick();

    // Both fires with count 1 hold the drain; then redirect stalls 4 cycles.
    fetch_req_fire = 1'b1;
    tick();
    fetch_req_fire = 1'b0;
    redirect_ready = 1'b0;
    flush_req      = 1'b1;
    flush_target   = 32'h0000_3abc;
    tick();
    fetch_req_fire = 1'b1;
    fetch_rsp_fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state($sformatf("both_%0d", i), DRAIN, 1);
    end
    fetch_req_fire = 1'b0;
    tick();
    fetch_rsp_fire = 1'b0;
    check_state("both_exit", REDIRECT, 0);
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("stall_%0d", i), 1'b0, 1'b1, 1'b1, 1'b1);
      check($sformatf("stall_%0d.pc", i), redirect_pc, 32'h0000_3abc);
      if (i < 3) tick();
    end
    redirect_ready = 1'b1;
    tick();
    check_outs("stall_ack", 1'b1, 1'b0, 1'b0, 1'b0);
    flush_req = 1'b0;
    tick();

    // Early req drop in DRAIN is ignored; reset while in REDIRECT.
    redirect_ready = 1'b0;
    stage_idle     = 4'b1110;
    flush_req      = 1'b1;
    flush_target   = 32'h0000_4000;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    check_state("early_drop", DRAIN, 0);
    stage_idle = 4'b1111;
    tick();
    check_state("rst_pre", REDIRECT, 0);
    fetch_req_fire = 1'b1;
    tick();
    fetch_req_fire = 1'b0;
    check_state("rst_pre2", REDIRECT, 1);
    rst_core = 1'b1;
    tick();
    check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid.pc", redirect_pc, 32'h0);
    check_state("rst_mid", IDLE, 0);
    rst_core       = 1'b0;
    redirect_ready = 1'b1;
    tick();

`ifdef HSV_CORE_FLUSH_TIMEOUT_EN
    // Stuck stage forces the watchdog after TO drain cycles.
    fetch_req_fire = 1'b1;
    tick();
    tick();
    fetch_req_fire = 1'b0;
    stage_idle   = 4'b1011;
    flush_req    = 1'b1;
    flush_target = 32'h0000_5000;
    for (int i = 1; i <= TO; i++) begin
      tick();
      check($sformatf("wd_c%0d.state", i), 32'(dbg.state), 32'(DRAIN));
    end
    tick();
    check_state("wd_fire", REDIRECT, 0);
    check("wd_fire.to", 32'(drain_timeout), 32'h1);
    tick();
    flush_req = 1'b0;
    tick();
    check_state("wd_idle", IDLE, 0);
    check("wd_sticky", 32'(drain_timeout), 32'h1);
    stage_idle = 4'b1111;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
